// File: rtl/stacker_pixel_renderer.sv
// -----------------------------------------------------------------------------
// stacker_pixel_renderer
//
// Turns the playfield occupancy grid of the stacker game into 8-bit RGB pixels
// for a VGA-style timing generator. Two pipeline stages sit between the pixel
// coordinates and the colour output. The sync signals travel through a matching
// two-stage delay, so all outputs stay aligned.
//
// The grid is copied into a snapshot register on every rising edge of vsync_in.
// Rendering reads only this snapshot, so a game-logic update during a frame
// never tears the picture. Cell column and row come from running counters, not
// from dividing PixelX and PixelY.
//
// Parameters
//   CELL_SIZE  cell edge length in pixels
//   GRID_COLS  playfield columns
//   GRID_ROWS  playfield rows
//   ORIGIN_X   PixelX of the left edge of the playfield
//   ORIGIN_Y   PixelY of the top edge of the playfield
//
// Ports
//   clk        pixel clock; all state changes on its rising edge
//   clr        asynchronous active-low reset
//   hsync_in   horizontal sync from the timing generator (active-high)
//   vsync_in   vertical sync from the timing generator (active-high)
//   vidon      active-video flag, aligned with PixelX/PixelY
//   PixelX     active-area column, +1 per clk while vidon=1
//   PixelY     active-area line
//   grid       occupancy, bit r*GRID_COLS+c = row r (from top), col c (from left)
//   game_over  enables blinking of the filled cells
//   hsync      hsync_in delayed by 2 clk
//   vsync      vsync_in delayed by 2 clk
//   rgb        colour {R[2:0],G[2:0],B[1:0]}, 2 clk after its pixel
// -----------------------------------------------------------------------------
module stacker_pixel_renderer #(
    parameter int CELL_SIZE = 32,
    parameter int GRID_COLS = 7,
    parameter int GRID_ROWS = 15,
    parameter int ORIGIN_X  = 288,
    parameter int ORIGIN_Y  = 60
) (
    input  logic                           clk,
    input  logic                           clr,
    input  logic                           hsync_in,
    input  logic                           vsync_in,
    input  logic                           vidon,
    input  logic [10:0]                    PixelX,
    input  logic [10:0]                    PixelY,
    input  logic [GRID_ROWS*GRID_COLS-1:0] grid,
    input  logic                           game_over,
    output logic                           hsync,
    output logic                           vsync,
    output logic [7:0]                     rgb
);

    localparam int CELLS = GRID_ROWS * GRID_COLS;
    localparam int SUB_W = (CELL_SIZE > 1) ? $clog2(CELL_SIZE) : 1;
    localparam int COL_W = $clog2(GRID_COLS + 1);
    localparam int ROW_W = $clog2(GRID_ROWS + 1);
    localparam int IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;

    localparam logic [10:0]      X_LO     = 11'(ORIGIN_X);
    localparam logic [10:0]      X_HI     = 11'(ORIGIN_X + GRID_COLS * CELL_SIZE);
    localparam logic [10:0]      Y_LO     = 11'(ORIGIN_Y);
    localparam logic [10:0]      Y_HI     = 11'(ORIGIN_Y + GRID_ROWS * CELL_SIZE);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(CELL_SIZE - 1);
    localparam logic [COL_W-1:0] COL_LIM  = COL_W'(GRID_COLS);
    localparam logic [ROW_W-1:0] ROW_LIM  = ROW_W'(GRID_ROWS);

    localparam logic [7:0] RGB_BLANK = 8'h00;
    localparam logic [7:0] RGB_BG    = 8'h02;
    localparam logic [7:0] RGB_LINE  = 8'h49;
    localparam logic [7:0] RGB_FILL  = 8'hFC;
    localparam logic [7:0] RGB_EMPTY = 8'h00;

    // ---------------------------------------------------------------- frame state
    logic             vsync_in_q;
    logic             vs_rise_s;
    logic [CELLS-1:0] snap_q, snap_d;
    logic [3:0]       frame_cnt_q, frame_cnt_d;
    logic             frame_valid_q, frame_valid_d;

    // ------------------------------------------------------------ column tracking
    logic             in_x_s, in_y_s, line_start_s;
    logic [SUB_W-1:0] sub_x_q, sub_x_d, cur_sub_x_s;
    logic [COL_W-1:0] col_q, col_d, cur_col_s;

    // --------------------------------------------------------------- row tracking
    logic             vidon_q;
    logic             line_end_s;
    logic             line_past_origin_q, line_past_origin_d;
    logic [SUB_W-1:0] sub_y_q, sub_y_d;
    logic [ROW_W-1:0] row_q, row_d;

    // -------------------------------------------------------------------- stage 1
    logic             s1_vid_q;
    logic             s1_in_grid_q;
    logic [COL_W-1:0] s1_col_q;
    logic [ROW_W-1:0] s1_row_q;
    logic             s1_edge_q;
    logic             s1_go_q;
    logic             edge_s;

    // -------------------------------------------------------------------- stage 2
    logic             cell_ok_s;
    logic [IDX_W-1:0] cell_idx_s;
    logic             cell_filled_s;
    logic             blink_s;
    logic [7:0]       rgb_q, rgb_d;
    logic [1:0]       hs_pipe_q;
    logic [1:0]       vs_pipe_q;

    assign vs_rise_s = vsync_in & ~vsync_in_q;

    // Snapshot, frame counter and "snapshot loaded" flag update on a vsync rise.
    always_comb begin
        snap_d        = snap_q;
        frame_cnt_d   = frame_cnt_q;
        frame_valid_d = frame_valid_q;
        if (vs_rise_s) begin
            snap_d        = grid;
            frame_cnt_d   = frame_cnt_q + 4'd1;
            frame_valid_d = 1'b1;
        end else begin
            snap_d        = snap_q;
            frame_cnt_d   = frame_cnt_q;
            frame_valid_d = frame_valid_q;
        end
    end

    // Frame-level registers.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            vsync_in_q    <= 1'b0;
            snap_q        <= '0;
            frame_cnt_q   <= 4'd0;
            frame_valid_q <= 1'b0;
        end else begin
            vsync_in_q    <= vsync_in;
            snap_q        <= snap_d;
            frame_cnt_q   <= frame_cnt_d;
            frame_valid_q <= frame_valid_d;
        end
    end

    // Playfield window and the column position of the current pixel. The
    // registered counters hold the position for the pixel after the previous
    // one; the first playfield pixel of a line forces them back to zero.
    always_comb begin
        in_x_s       = vidon && (PixelX >= X_LO) && (PixelX < X_HI);
        in_y_s       = (PixelY >= Y_LO) && (PixelY < Y_HI);
        line_start_s = vidon && (PixelX == X_LO);
        cur_sub_x_s  = sub_x_q;
        cur_col_s    = col_q;
        if (line_start_s) begin
            cur_sub_x_s = '0;
            cur_col_s   = '0;
        end else begin
            cur_sub_x_s = sub_x_q;
            cur_col_s   = col_q;
        end
    end

    // Next column position; col saturates at GRID_COLS, which reads as outside.
    always_comb begin
        sub_x_d = cur_sub_x_s;
        col_d   = cur_col_s;
        if (in_x_s) begin
            if (cur_sub_x_s == SUB_LAST) begin
                sub_x_d = '0;
                col_d   = (cur_col_s < COL_LIM) ? (cur_col_s + COL_W'(1)) : cur_col_s;
            end else begin
                sub_x_d = cur_sub_x_s + SUB_W'(1);
                col_d   = cur_col_s;
            end
        end else begin
            sub_x_d = cur_sub_x_s;
            col_d   = cur_col_s;
        end
    end

    // Row position advances at the end of each line at or below the top edge.
    // vsync_in wins over a line ending in the same cycle.
    always_comb begin
        line_end_s         = vidon_q & ~vidon;
        line_past_origin_d = vidon ? (PixelY >= Y_LO) : line_past_origin_q;
        sub_y_d            = sub_y_q;
        row_d              = row_q;
        if (vsync_in) begin
            sub_y_d = '0;
            row_d   = '0;
        end else if (line_end_s && line_past_origin_q) begin
            if (sub_y_q == SUB_LAST) begin
                sub_y_d = '0;
                row_d   = (row_q < ROW_LIM) ? (row_q + ROW_W'(1)) : row_q;
            end else begin
                sub_y_d = sub_y_q + SUB_W'(1);
                row_d   = row_q;
            end
        end else begin
            sub_y_d = sub_y_q;
            row_d   = row_q;
        end
    end

    // Column and row counters.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sub_x_q            <= '0;
            col_q              <= '0;
            vidon_q            <= 1'b0;
            line_past_origin_q <= 1'b0;
            sub_y_q            <= '0;
            row_q              <= '0;
        end else begin
            sub_x_q            <= sub_x_d;
            col_q              <= col_d;
            vidon_q            <= vidon;
            line_past_origin_q <= line_past_origin_d;
            sub_y_q            <= sub_y_d;
            row_q              <= row_d;
        end
    end

    // The first pixel column and first line of each cell draw the grid lines.
    assign edge_s = (cur_sub_x_s == '0) || (sub_y_q == '0);

    // Stage 1: capture the pixel's position, class and blanking. Video stays
    // blank until a snapshot has been loaded after reset.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            s1_vid_q     <= 1'b0;
            s1_in_grid_q <= 1'b0;
            s1_col_q     <= '0;
            s1_row_q     <= '0;
            s1_edge_q    <= 1'b0;
            s1_go_q      <= 1'b0;
        end else begin
            s1_vid_q     <= vidon & frame_valid_q;
            s1_in_grid_q <= in_x_s & in_y_s;
            s1_col_q     <= cur_col_s;
            s1_row_q     <= row_q;
            s1_edge_q    <= edge_s;
            s1_go_q      <= game_over;
        end
    end

    // Stage 2 colour selection. An out-of-range counter counts as outside the
    // grid, so the snapshot is never indexed past its last cell.
    always_comb begin
        cell_ok_s     = s1_in_grid_q && (s1_col_q < COL_LIM) && (s1_row_q < ROW_LIM);
        cell_idx_s    = '0;
        if (cell_ok_s) begin
            cell_idx_s = IDX_W'(int'(s1_row_q) * GRID_COLS + int'(s1_col_q));
        end else begin
            cell_idx_s = '0;
        end
        cell_filled_s = snap_q[cell_idx_s];
        blink_s       = s1_go_q & frame_cnt_q[3];
        rgb_d         = RGB_BLANK;
        if (!s1_vid_q) begin
            rgb_d = RGB_BLANK;
        end else if (!cell_ok_s) begin
            rgb_d = RGB_BG;
        end else if (s1_edge_q) begin
            rgb_d = RGB_LINE;
        end else if (cell_filled_s && !blink_s) begin
            rgb_d = RGB_FILL;
        end else begin
            rgb_d = RGB_EMPTY;
        end
    end

    // Stage 2 output registers and the matching two-stage sync delay.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            rgb_q     <= 8'h00;
            hs_pipe_q <= 2'b00;
            vs_pipe_q <= 2'b00;
        end else begin
            rgb_q     <= rgb_d;
            hs_pipe_q <= {hs_pipe_q[0], hsync_in};
            vs_pipe_q <= {vs_pipe_q[0], vsync_in};
        end
    end

    assign rgb   = rgb_q;
    assign hsync = hs_pipe_q[1];
    assign vsync = vs_pipe_q[1];

endmodule
